// File: rtl/key_pkg.sv
// Shared types and sizes for the keypad front-end.
package key_pkg;
    localparam int KEY_W = 4;
    localparam int NKEYS = 16;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_WAIT_PRESS,
        KS_HELD,
        KS_WAIT_RELEASE
    } key_state_e;
endpackage

// File: rtl/key_fifo.sv
// Show-ahead event FIFO; head data reads 0 when empty. A push while full is
// accepted only if a pop frees the head slot in the same cycle.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]             count_q, count_d;
    logic                    do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q] <= din_i;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/keyenc.sv
// 16-input priority key encoder; the lowest-numbered pressed key wins.
module keyenc
    import key_pkg::*;
(
    input  logic [NKEYS-1:0] keys,
    output logic             key_in,
    output logic [KEY_W-1:0] key_val
);
    always_comb begin
        key_in  = |keys;
        key_val = '0;
        // Scan high to low so the lowest set bit is the last one written.
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (keys[i]) key_val = KEY_W'(i);
        end
    end
endmodule

// File: rtl/key_ctrl.sv
// Keypad front-end: 2-flop sync, priority encode, press/release debounce FSM
// producing one event per press, buffered in a show-ahead FIFO.
module key_ctrl
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NKEYS-1:0] keys,
    input  logic             key_ack,
    input  logic             clear_ovf,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_code,
    output logic             overflow,
    output logic             busy
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [FCW-1:0] DEPTH_CNT = FCW'(FIFO_DEPTH);

    logic [NKEYS-1:0] sync1_q, sync2_q;
    logic             any;
    logic [KEY_W-1:0] val;

    key_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic             push;

    logic             pop, fifo_empty, fifo_full, drop;
    logic [FCW-1:0]   fifo_count;
    logic             ovf_q, ovf_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= keys;
            sync2_q <= sync1_q;
        end
    end

    keyenc u_enc (
        .keys    (sync2_q),
        .key_in  (any),
        .key_val (val)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        push    = 1'b0;
        unique case (state_q)
            KS_IDLE: begin
                if (any) begin
                    cand_d  = val;
                    cnt_d   = CNT_ONE;
                    state_d = KS_WAIT_PRESS;
                end
            end
            KS_WAIT_PRESS: begin
                // A changed key aborts to IDLE; it gets re-evaluated next cycle.
                if (!any || val != cand_q) begin
                    state_d = KS_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    push    = 1'b1;
                    state_d = KS_HELD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            KS_HELD: begin
                if (!any) begin
                    cnt_d   = CNT_ONE;
                    state_d = KS_WAIT_RELEASE;
                end
            end
            KS_WAIT_RELEASE: begin
                if (any) begin
                    state_d = KS_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = KS_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = KS_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= KS_IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    assign pop  = key_ack & ~fifo_empty;
    assign drop = push & fifo_full & ~pop;

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (KEY_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (cand_q),
        .dout_o  (key_code),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    // Set beats clear when both land in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (clear_ovf) ovf_d = 1'b0;
        if (drop)      ovf_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign key_valid = ~fifo_empty;
    assign overflow  = ovf_q;
    assign busy      = (state_q != KS_IDLE);

    a_count_bound: assert property (@(posedge clock) disable iff (!reset)
        fifo_count <= DEPTH_CNT);
endmodule

// File: doc/key_ctrl.md
# key_ctrl

Keypad front-end controller that sequences the 16-input priority key encoder (`keyenc`) into clean, one-shot key events. It synchronizes raw switch inputs, debounces the encoded key, emits exactly one event per press (no auto-repeat), and buffers events in a small FIFO. A valid/ack handshake hands the events to the CPU/IO side. The block sits between the board keypad pins and the processor's input port.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000: consecutive stable cycles required for a press or a release. Legal range is ≥ 2. Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- `FIFO_DEPTH`, default 4: event buffer entries. Must be a power of two, ≥ 2.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  reset, asynchronous and active-low.
- `keys`  in  16  raw key levels, asynchronous to `clock`; bit i = key i pressed.
- `key_ack`  in  1  consumer accepts the head event when `key_valid` is 1.
- `clear_ovf`  in  1  clears `overflow`.
- `key_valid`  out  1  FIFO non-empty.
- `key_code`  out  4  head event key number (0–15); reads 0 when empty.
- `overflow`  out  1  sticky flag; an event was dropped because the FIFO was full.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- **Synchronizer.** `keys` passes through two flops, reset value 0. `keyenc` is driven by the 2nd stage and yields `any` (key_in) and `val` (key_val). The lowest set bit wins.
- **FSM states:** IDLE, WAIT_PRESS, HELD, WAIT_RELEASE.
  - **IDLE.** If `any`=1, set `cand`←`val` and `cnt`←1, then go to WAIT_PRESS.
  - **WAIT_PRESS.**
    - If `any`=0 or `val`≠`cand`, go to IDLE. There is no direct restart; the new key is re-evaluated from IDLE on the next cycle.
    - Otherwise, if `cnt`==`DEBOUNCE_CYCLES`-1, push `cand` into the FIFO and go to HELD.
    - Otherwise, increment `cnt`.
  - **HELD.** Stay while `any`=1, regardless of `val` changes. Additional or other keys are ignored until full release. If `any`=0, set `cnt`←1 and go to WAIT_RELEASE.
  - **WAIT_RELEASE.**
    - If `any`=1, go to HELD.
    - Else if `cnt`==`DEBOUNCE_CYCLES`-1, go to IDLE.
    - Else increment `cnt`.
- **FIFO.** Show-ahead: `key_code` is the head entry. Pop when `key_valid`&`key_ack`.
  - A push while full is dropped and sets `overflow`.
  - A push and a pop in the same cycle while full are both performed; the count is unchanged and there is no overflow.
  - A push and a pop in the same cycle while non-full: count unchanged.
  - `key_ack` while empty is ignored.
- **overflow.** Set on a dropped push; cleared by `clear_ovf`. If both occur in the same cycle, set wins.
- **Reset values.** All outputs are 0. FSM is in IDLE; `cnt`, `cand`, FIFO pointers, count and synchronizers are 0.
- **Reset mid-operation.** A partial debounce is abandoned and FIFO contents are discarded.

## Timing
- Numbering: edge 1 is the first rising edge sampling a new stable `keys` value.
  - The sync output is valid after edge 2.
  - WAIT_PRESS is entered at edge 3.
  - The push occurs at edge `DEBOUNCE_CYCLES`+2.
  - `key_valid` is 1 after that edge. With `DEBOUNCE_CYCLES`=4, that is after edge 6.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles at the sync output produces no event.
- Minimum interval between two events of the same key: press debounce + hold ≥1 cycle + release debounce.
- `key_valid` falls on the edge that pops the last entry. `key_code` updates on the same edge as the pop.
- All outputs are registered or decoded directly from registers. There is no combinational path from `keys` or `key_ack` to any output.

## Structure
- Shared package `key_pkg` holds:
  - the FSM state enum: `KS_IDLE`, `KS_WAIT_PRESS`, `KS_HELD`, `KS_WAIT_RELEASE`;
  - `KEY_W`=4 and `NKEYS`=16.
- `keyenc` is instantiated unchanged.
- One sub-module is natural: `key_fifo` (parameterised depth, width `KEY_W`, show-ahead, with full/empty/count). The FSM, counter and synchronizer stay in `key_ctrl`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `FIFO_DEPTH`=4.

1. **Reset.** Assert `reset`=0 mid-debounce with key 5 held. Required: all outputs 0 immediately (asynchronous). After release of reset, key 5 still held gives `key_code`=5 at edge 6.
2. **Clean press.** `keys`=16'h0020 for 10 cycles, then 0, then `key_ack` pulsed. Required: `key_valid`=1 after edge 6 with `key_code`=5; exactly one event; `key_valid`=0 after the ack edge.
3. **Bounce.**
   - `keys`=16'h0008 for 2 cycles, then 0 for 1 cycle, repeated 3 times. Required: no event.
   - Then hold 16'h0008. Required: one event with `key_code`=3.
4. **Priority/held.** Press 16'h8000, then after the event add bit 2 (16'h8004). Required: no second event until all keys have been released for ≥4 cycles; a re-press of 16'h0004 then yields `key_code`=2.
5. **Overflow.** Five separate presses (keys 0, 1, 2, 3, 4) with no ack.
   - Required: codes 0, 1, 2, 3 are retained and `overflow`=1.
   - `clear_ovf` pulse. Required: `overflow`=0.
   - Then ack in the same cycle as a push while full. Required: no overflow, and the count stays 4.
6. **Drain.** Ack 4 times. Required: `key_code` sequence 0, 1, 2, 3; then `key_valid`=0 and `key_code`=0.
